lat_scoreboard: RTL and testbench
=================================

LAT_SCOREBOARD -- requirements
Module: lat_scoreboard

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; no other clock or reset exists in the block.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  instruction present in the issue stage
- issue_long  in  1  instruction goes to a multi-cycle unit
- issue_unit  in  1  target unit: 0 = MDU (mul/div), 1 = FPU
- issue_rd_we  in  1  instruction writes a destination register
- issue_rd_fp  in  1  destination is an FPR (0 = GPR)
- issue_rd  in  5  destination address
- gpr_raddr1, gpr_raddr2  in  5 each  GPR source addresses; 0 means unused
- fpr_re1..3  in  1 each  FPR source read enables
- fpr_raddr1..3  in  5 each  FPR source addresses
- unit_done  in  2  completion request; bit0 = MDU, bit1 = FPU; held until granted
- flush  in  1  pipeline flush; kills all in-flight long-latency ops
- sb_stall  out  1  issue stage must hold
- issue_fire  out  1  issue_valid & ~sb_stall
- wb_grant  out  2  one-hot writeback grant to a unit
- wb_valid  out  1  a register write is committed this cycle
- wb_rd_fp  out  1  writeback destination class
- wb_rd  out  5  writeback destination address

Function
REQ-003 SHALL keep gpr_pending[31:1], fpr_pending[31:0], and a per-unit record {busy, rd_we, rd_fp, rd}.
REQ-004 GPR x0 SHALL never be marked pending and SHALL never cause a stall.
REQ-005 SHALL assert sb_stall combinationally, from the current registered state, when issue_valid and any of these hold:
- RAW: a used GPR source, or an enabled FPR source, is pending;
- WAW: issue_rd_we and the destination is pending (x0 excluded for GPR);
- structural: issue_long and the busy flag of the target unit is set.
REQ-006 sb_stall SHALL be 0 when issue_valid=0 or flush=1.
REQ-007 On issue_fire & issue_long & ~flush, the next cycle SHALL:
- set the target unit record to busy, capturing rd_we, rd_fp and rd;
- if rd_we, set the matching pending bit.
REQ-008 Short ops (issue_long=0) SHALL never alter the state; they are subject to RAW/WAW stalls only.
REQ-009 Writeback arbiter: candidates are unit_done[i] & busy[i].
- If exactly one candidate exists, it SHALL be granted.
- If both exist, the unit not granted last SHALL be granted (round-robin pointer).
- The pointer SHALL update only on a grant.
REQ-010 wb_grant SHALL be combinational in the same cycle as the request; at most one bit set; all zero when flush=1.
REQ-011 With a grant, wb_valid SHALL equal the granted record's rd_we, and wb_rd_fp / wb_rd SHALL be driven from that record. Without a grant, wb_valid=0 and wb_rd_fp=0, wb_rd=0.
REQ-012 On a grant, the next cycle SHALL clear the unit's busy flag and, if rd_we, its pending bit.
REQ-013 A set and a clear of the same bit in one cycle SHALL result in set.
REQ-014 A unit freed by a grant SHALL accept a new issue no earlier than the following cycle; no same-cycle reuse.
REQ-015 When flush=1, the next cycle SHALL clear all pending bits and busy flags; issue and grants in the flush cycle SHALL have no effect.
REQ-016 unit_done on a non-busy unit SHALL be ignored.

Reset
REQ-017 While rst=1, state SHALL clear on each clock edge: pending bits = 0, busy = 0, records = 0, round-robin pointer favours MDU (MDU is granted first on a tie).
REQ-018 Outputs after reset: sb_stall=0, wb_grant=0, wb_valid=0, wb_rd=0, wb_rd_fp=0. issue_fire follows issue_valid.
REQ-019 rst=1 mid-operation SHALL abandon all in-flight ops, with the same effect as flush.

Verification
REQ-020 MDU op issued with rd=x5 (GPR); next cycle, an op with gpr_raddr1=5 -> sb_stall=1 until unit_done[0] is granted with wb_rd=5, wb_valid=1; sb_stall=0 the cycle after.
REQ-021 FPU op issued with rd=f3, then a second FPU op -> structural stall. The same stall also occurs with no register overlap.
REQ-022 Both units busy and unit_done=2'b11 on the first tie after reset:
- first cycle -> wb_grant=01;
- next cycle -> 10;
- on the next tie -> 01.
REQ-023 Pending x7 and f7 present; flush=1 with unit_done=2'b01 -> wb_grant=00; next cycle all pending bits are 0 and an op reading x7 issues with no stall.
REQ-024 Issue op with rd=x0, rd_we=1 on the MDU -> no pending bit is set; sb_stall depends only on MDU busy; a reader of x0 never stalls.
REQ-025 MDU op with rd_we=0 completes -> wb_grant=01, wb_valid=0, and the busy flag clears.

Source files
------------

// File: rtl/lat_scoreboard.sv
// Register scoreboard for two long-latency units (MDU, FPU): tracks pending GPR/FPR
// destinations, stalls hazardous issues and arbitrates unit writebacks round-robin.
module lat_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       issue_long,
    input  logic       issue_unit,
    input  logic       issue_rd_we,
    input  logic       issue_rd_fp,
    input  logic [4:0] issue_rd,
    input  logic [4:0] gpr_raddr1,
    input  logic [4:0] gpr_raddr2,
    input  logic       fpr_re1,
    input  logic       fpr_re2,
    input  logic       fpr_re3,
    input  logic [4:0] fpr_raddr1,
    input  logic [4:0] fpr_raddr2,
    input  logic [4:0] fpr_raddr3,
    input  logic [1:0] unit_done,
    input  logic       flush,
    output logic       sb_stall,
    output logic       issue_fire,
    output logic [1:0] wb_grant,
    output logic       wb_valid,
    output logic       wb_rd_fp,
    output logic [4:0] wb_rd
);

    typedef struct packed {
        logic       busy;
        logic       rd_we;
        logic       rd_fp;
        logic [4:0] rd;
    } unit_rec_t;

    // Bit 0 of the GPR vector is never set, so x0 can be indexed without a special case.
    logic [31:0]      gpr_pend_q;
    logic [31:0]      fpr_pend_q;
    unit_rec_t [1:0]  rec_q;
    logic             rr_fpu_q;   // 1: FPU wins the next tie

    logic raw_hazard;
    logic waw_hazard;
    logic struct_hazard;
    logic granted;
    logic grant_sel;
    logic [1:0] cand;

    assign raw_hazard = ((gpr_raddr1 != 5'd0) && gpr_pend_q[gpr_raddr1])
                     || ((gpr_raddr2 != 5'd0) && gpr_pend_q[gpr_raddr2])
                     || (fpr_re1 && fpr_pend_q[fpr_raddr1])
                     || (fpr_re2 && fpr_pend_q[fpr_raddr2])
                     || (fpr_re3 && fpr_pend_q[fpr_raddr3]);

    assign waw_hazard = issue_rd_we &&
                        (issue_rd_fp ? fpr_pend_q[issue_rd]
                                     : ((issue_rd != 5'd0) && gpr_pend_q[issue_rd]));

    // Busy is registered, so a unit freed by this cycle's grant still looks busy here.
    assign struct_hazard = issue_long && rec_q[issue_unit].busy;

    assign sb_stall   = issue_valid && !flush && (raw_hazard || waw_hazard || struct_hazard);
    assign issue_fire = issue_valid && !sb_stall;

    assign cand = unit_done & {rec_q[1].busy, rec_q[0].busy};

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        wb_grant = 2'b00;
        if (!flush) begin
            case (cand)
                2'b01:   wb_grant = 2'b01;
                2'b10:   wb_grant = 2'b10;
                2'b11:   wb_grant = rr_fpu_q ? 2'b10 : 2'b01;
                default: wb_grant = 2'b00;
            endcase
        end
    end

    assign granted   = |wb_grant;
    assign grant_sel = wb_grant[1];
    assign wb_valid  = granted && rec_q[grant_sel].rd_we;
    assign wb_rd_fp  = granted && rec_q[grant_sel].rd_fp;
    assign wb_rd     = granted ? rec_q[grant_sel].rd : 5'd0;

    // NOTE: non-blocking assignments only; where a grant clear and an issue set hit the
    // same bit, the later issue assignment wins, which gives set-over-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_pend_q <= '0;
            fpr_pend_q <= '0;
            rec_q      <= '0;
            rr_fpu_q   <= 1'b0;
        end else if (flush) begin
            gpr_pend_q <= '0;
            fpr_pend_q <= '0;
            rec_q[0].busy <= 1'b0;
            rec_q[1].busy <= 1'b0;
        end else begin
            if (granted) begin
                rec_q[grant_sel].busy <= 1'b0;
                rr_fpu_q <= !grant_sel;
                if (rec_q[grant_sel].rd_we) begin
                    if (rec_q[grant_sel].rd_fp)
                        fpr_pend_q[rec_q[grant_sel].rd] <= 1'b0;
                    else
                        gpr_pend_q[rec_q[grant_sel].rd] <= 1'b0;
                end
            end
            if (issue_fire && issue_long) begin
                rec_q[issue_unit] <= '{busy: 1'b1, rd_we: issue_rd_we,
                                       rd_fp: issue_rd_fp, rd: issue_rd};
                if (issue_rd_we) begin
                    if (issue_rd_fp)
                        fpr_pend_q[issue_rd] <= 1'b1;
                    else if (issue_rd != 5'd0)
                        gpr_pend_q[issue_rd] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lat_scoreboard.sv
// Bench for lat_scoreboard: directed vector table for the hazard/arbitration corners,
// then randomized traffic compared against a register-set reference model.
module tb_lat_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_long, issue_unit, issue_rd_we, issue_rd_fp;
    logic [4:0] issue_rd, gpr_raddr1, gpr_raddr2;
    logic       fpr_re1, fpr_re2, fpr_re3;
    logic [4:0] fpr_raddr1, fpr_raddr2, fpr_raddr3;
    logic [1:0] unit_done;
    logic       flush;
    logic       sb_stall, issue_fire, wb_valid, wb_rd_fp;
    logic [1:0] wb_grant;
    logic [4:0] wb_rd;

    always #5 clk = ~clk;

    lat_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_unit(issue_unit),
        .issue_rd_we(issue_rd_we), .issue_rd_fp(issue_rd_fp), .issue_rd(issue_rd),
        .gpr_raddr1(gpr_raddr1), .gpr_raddr2(gpr_raddr2),
        .fpr_re1(fpr_re1), .fpr_re2(fpr_re2), .fpr_re3(fpr_re3),
        .fpr_raddr1(fpr_raddr1), .fpr_raddr2(fpr_raddr2), .fpr_raddr3(fpr_raddr3),
        .unit_done(unit_done), .flush(flush),
        .sb_stall(sb_stall), .issue_fire(issue_fire), .wb_grant(wb_grant),
        .wb_valid(wb_valid), .wb_rd_fp(wb_rd_fp), .wb_rd(wb_rd)
    );

    typedef struct {
        logic       valid, long_op, unit, rd_we, rd_fp;
        logic [4:0] rd, ra1, ra2;
        logic [2:0] fre;
        logic [4:0] fa1, fa2, fa3;
        logic [1:0] done;
        logic       flush, rst;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       stall;
        logic [1:0] grant;
        logic       wbv, wbfp;
        logic [4:0] wbrd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic l, input logic u, input logic we,
                                 input logic fp, input logic [4:0] rd, input logic [4:0] ra1,
                                 input logic re1, input logic [4:0] fa1, input logic [1:0] done,
                                 input logic fl, input logic r);
        stim_t s;
        s.valid = v;  s.long_op = l; s.unit = u; s.rd_we = we; s.rd_fp = fp; s.rd = rd;
        s.ra1 = ra1;  s.ra2 = 5'd0;  s.fre = {2'b00, re1};
        s.fa1 = fa1;  s.fa2 = 5'd0;  s.fa3 = 5'd0;
        s.done = done; s.flush = fl; s.rst = r;
        return s;
    endfunction

    function automatic vec_t vx(input stim_t s, input logic st, input logic [1:0] g,
                                input logic wv, input logic wf, input logic [4:0] wr);
        vec_t x;
        x.s = s; x.stall = st; x.grant = g; x.wbv = wv; x.wbfp = wf; x.wbrd = wr;
        return x;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; flush = s.flush; unit_done = s.done;
        issue_valid = s.valid; issue_long = s.long_op; issue_unit = s.unit;
        issue_rd_we = s.rd_we; issue_rd_fp = s.rd_fp; issue_rd = s.rd;
        gpr_raddr1 = s.ra1; gpr_raddr2 = s.ra2;
        fpr_re1 = s.fre[0]; fpr_re2 = s.fre[1]; fpr_re3 = s.fre[2];
        fpr_raddr1 = s.fa1; fpr_raddr2 = s.fa2; fpr_raddr3 = s.fa3;
    endtask

    // Reference model: plain register-set bookkeeping, one record per unit.
    bit       m_gpr [32];
    bit       m_fpr [32];
    bit       m_busy [2];
    bit       m_we [2];
    bit       m_fp [2];
    bit [4:0] m_rd [2];
    int       m_last = 1;   // unit granted most recently; 1 makes MDU win the first tie

    function automatic bit m_reg_pending(input bit fp, input logic [4:0] a);
        if (fp) return m_fpr[a];
        return (a != 0) && m_gpr[a];
    endfunction

    task automatic m_eval(input stim_t s, output logic stall, output int g);
        bit hazard;
        bit c0, c1;
        hazard = m_reg_pending(0, s.ra1) || m_reg_pending(0, s.ra2)
              || (s.fre[0] && m_reg_pending(1, s.fa1))
              || (s.fre[1] && m_reg_pending(1, s.fa2))
              || (s.fre[2] && m_reg_pending(1, s.fa3))
              || (s.rd_we && m_reg_pending(s.rd_fp, s.rd))
              || (s.long_op && m_busy[s.unit]);
        stall = s.valid && !s.flush && hazard;
        c0 = s.done[0] && m_busy[0];
        c1 = s.done[1] && m_busy[1];
        if (s.flush)        g = -1;
        else if (c0 && c1)  g = 1 - m_last;
        else if (c0)        g = 0;
        else if (c1)        g = 1;
        else                g = -1;
    endtask

    task automatic m_update(input stim_t s, input logic stall, input int g);
        if (s.rst || s.flush) begin
            for (int i = 0; i < 32; i++) begin m_gpr[i] = 0; m_fpr[i] = 0; end
            m_busy[0] = 0; m_busy[1] = 0;
            if (s.rst) begin
                m_last = 1;
                for (int u = 0; u < 2; u++) begin m_we[u] = 0; m_fp[u] = 0; m_rd[u] = 0; end
            end
            return;
        end
        if (g >= 0) begin
            m_busy[g] = 0;
            m_last = g;
            if (m_we[g]) begin
                if (m_fp[g]) m_fpr[m_rd[g]] = 0;
                else         m_gpr[m_rd[g]] = 0;
            end
        end
        if (s.valid && !stall && s.long_op) begin
            m_busy[s.unit] = 1; m_we[s.unit] = s.rd_we;
            m_fp[s.unit] = s.rd_fp; m_rd[s.unit] = s.rd;
            if (s.rd_we) begin
                if (s.rd_fp)         m_fpr[s.rd] = 1;
                else if (s.rd != 0)  m_gpr[s.rd] = 1;
            end
        end
    endtask

    task automatic compare(input string tag, input logic stall, input logic [1:0] g,
                           input logic wv, input logic wf, input logic [4:0] wr, input logic v);
        check({tag, " sb_stall"},   8'(sb_stall),   8'(stall));
        check({tag, " issue_fire"}, 8'(issue_fire), 8'(v && !stall));
        check({tag, " wb_grant"},   8'(wb_grant),   8'(g));
        check({tag, " wb_valid"},   8'(wb_valid),   8'(wv));
        check({tag, " wb_rd_fp"},   8'(wb_rd_fp),   8'(wf));
        check({tag, " wb_rd"},      8'(wb_rd),      8'(wr));
    endtask

    vec_t tbl[$];

    initial begin
        stim_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,2'b00,0,0);
        drive(idle);

        // rst / first issue
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b00,0,1), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,5,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        // MDU writes x5, reader of x5 waits for the writeback
        tbl.push_back(vx(mk(1,1,0,1,0,5,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,5,0,0,2'b00,0,0), 1, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,5,0,0,2'b01,0,0), 1, 2'b01, 1,0,5));
        tbl.push_back(vx(mk(1,0,0,0,0,0,5,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        // FPU structural hazard with and without register overlap
        tbl.push_back(vx(mk(1,1,1,1,1,3,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,1,1,1,9,0,0,0,2'b00,0,0), 1, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,0,1,3,2'b00,0,0), 1, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0), 0, 2'b10, 1,1,3));
        tbl.push_back(vx(mk(1,1,1,1,1,9,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        // round-robin: first tie after reset goes to MDU
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b00,0,1), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,0,1,0,7,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,1,1,1,7,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b11,0,0), 0, 2'b01, 1,0,7));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b11,0,0), 0, 2'b10, 1,1,7));
        tbl.push_back(vx(mk(1,1,0,0,0,0,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,1,0,0,0,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b11,0,0), 0, 2'b01, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0), 0, 2'b10, 0,0,0));
        // flush with x7/f7 pending: no grant, issue in the flush cycle is dropped
        tbl.push_back(vx(mk(1,1,0,1,0,7,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,1,1,1,7,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,1,1,1,12,7,0,0,2'b01,1,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,0,1,12,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,0,0,0,0,7,1,7,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b01,0,0), 0, 2'b01, 0,0,0));
        // x0 destination never pends; freed unit not reusable in its grant cycle
        tbl.push_back(vx(mk(1,1,0,1,0,0,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,1,0,0,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,1,0,1,0,4,0,0,0,2'b01,0,0), 1, 2'b01, 1,0,0));
        tbl.push_back(vx(mk(1,1,0,1,0,4,0,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,4,0,0,2'b00,0,0), 1, 2'b00, 0,0,0));
        // reset mid-operation, then done on idle units is ignored
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b00,0,1), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(1,0,0,0,0,0,4,0,0,2'b00,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b01,0,0), 0, 2'b00, 0,0,0));
        tbl.push_back(vx(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0), 0, 2'b00, 0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].s);
            #1;
            compare($sformatf("vec%0d", i), tbl[i].stall, tbl[i].grant,
                    tbl[i].wbv, tbl[i].wbfp, tbl[i].wbrd, tbl[i].s.valid);
        end

        // randomized traffic against the model, starting from a reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stim_t s;
            logic  e_stall;
            int    g;
            s.valid   = ($urandom_range(0, 9) < 7);
            s.long_op = 1'($urandom_range(0, 1));
            s.unit    = 1'($urandom_range(0, 1));
            s.rd_we   = ($urandom_range(0, 3) != 0);
            s.rd_fp   = 1'($urandom_range(0, 1));
            s.rd      = 5'($urandom_range(0, 7));
            s.ra1     = 5'($urandom_range(0, 7));
            s.ra2     = 5'($urandom_range(0, 7));
            s.fre     = 3'($urandom_range(0, 7));
            s.fa1     = 5'($urandom_range(0, 7));
            s.fa2     = 5'($urandom_range(0, 7));
            s.fa3     = 5'($urandom_range(0, 7));
            s.done    = 2'($urandom_range(0, 3));
            s.flush   = ($urandom_range(0, 29) == 0);
            s.rst     = (cyc == 0) || ($urandom_range(0, 99) == 0);
            @(negedge clk);
            drive(s);
            #1;
            m_eval(s, e_stall, g);
            if (g >= 0)
                compare($sformatf("rnd%0d", cyc), e_stall, (g == 1) ? 2'b10 : 2'b01,
                        m_we[g], m_fp[g], m_rd[g], s.valid);
            else
                compare($sformatf("rnd%0d", cyc), e_stall, 2'b00, 1'b0, 1'b0, 5'd0, s.valid);
            m_update(s, e_stall, g);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
